// File: rtl/cq_pkg.sv
// cq_pkg: shared defaults and helpers for the parametrised circular queue
package cq_pkg;
  localparam int DEF_DATA_W = 16;
  localparam int DEF_DEPTH = 16;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
  function automatic int next_ptr(input int ptr, input int depth);
    return (ptr == depth - 1) ? 0 : ptr + 1;
  endfunction
endpackage

// File: rtl/cq_wrap_ctr.sv
// cq_wrap_ctr: enable-driven pointer that wraps at DEPTH-1 back to 0
module cq_wrap_ctr
  import cq_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  localparam int PTR_W = clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset_,
  input  logic             en,
  output logic [PTR_W-1:0] ptr
);
  logic [PTR_W-1:0] ptr_d, ptr_q;
  always_comb ptr_d = en ? PTR_W'(next_ptr(int'(ptr_q), DEPTH)) : ptr_q;
  always_ff @(posedge clk or negedge reset_)
    if (!reset_) ptr_q <= '0;
    else ptr_q <= ptr_d;
  assign ptr = ptr_q;
endmodule

// File: rtl/circ_queue_param.sv
// circ_queue_param: circular queue of any depth with occupancy, thresholds and sticky error flags
module circ_queue_param
  import cq_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH = DEF_DEPTH,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2,
  localparam int CNT_W = clog2(DEPTH + 1),
  localparam int PTR_W = clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset_,
  input  logic              push,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              pop,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic [CNT_W-1:0]  count,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic              overflow,
  output logic              underflow,
  input  logic              err_clr
);
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rd_data_d, rd_data_q;
  logic [CNT_W-1:0] count_d, count_q;
  logic rd_valid_d, rd_valid_q, ovf_d, ovf_q, unf_d, unf_q;
  logic push_ok, pop_ok;
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  cq_wrap_ctr #(.DEPTH(DEPTH)) u_wr (.clk(clk), .reset_(reset_), .en(push_ok), .ptr(wr_ptr));
  cq_wrap_ctr #(.DEPTH(DEPTH)) u_rd (.clk(clk), .reset_(reset_), .en(pop_ok), .ptr(rd_ptr));
  assign full = count_q == CNT_W'(DEPTH);
  assign empty = count_q == '0;
  assign almost_full = int'(count_q) >= AF_LEVEL;
  assign almost_empty = int'(count_q) <= AE_LEVEL;
  always_comb begin
    push_ok = push & (~full | pop);
    pop_ok = pop & ~empty;
    count_d = (push_ok & ~pop_ok) ? count_q + 1'b1 : (pop_ok & ~push_ok) ? count_q - 1'b1 : count_q;
    rd_data_d = pop_ok ? mem_q[rd_ptr] : rd_data_q;
    rd_valid_d = pop_ok;
    ovf_d = (ovf_q & ~err_clr) | (push & ~push_ok);
    unf_d = (unf_q & ~err_clr) | (pop & ~pop_ok);
  end
  always_ff @(posedge clk or negedge reset_)
    if (!reset_) begin
      count_q <= '0;
      rd_data_q <= '0;
      rd_valid_q <= 1'b0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      count_q <= count_d;
      rd_data_q <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  always_ff @(posedge clk)
    if (push_ok) mem_q[wr_ptr] <= wr_data;
  assign rd_data = rd_data_q;
  assign rd_valid = rd_valid_q;
  assign count = count_q;
  assign overflow = ovf_q;
  assign underflow = unf_q;
endmodule

// File: tb/tb_circ_queue_param.sv
// tb_circ_queue_param: scoreboard bench for a depth-4 and a depth-5 queue instance
module tb_circ_queue_param;
  logic clk = 1'b0;
  logic reset_ = 1'b0;
  logic push4 = 1'b0, pop4 = 1'b0, clr4 = 1'b0;
  logic push5 = 1'b0, pop5 = 1'b0, clr5 = 1'b0;
  logic [7:0] wd4 = '0, wd5 = '0, rd4, rd5;
  logic rv4, rv5, full4, full5, empty4, empty5, af4, af5, ae4, ae5, ovf4, ovf5, unf4, unf5;
  logic [2:0] count4, count5;
  int checks = 0, errors = 0;
  logic [7:0] exp4[$], exp5[$], mq[$];

  always #5 clk = ~clk;

  circ_queue_param #(.DATA_W(8), .DEPTH(4), .AF_LEVEL(3), .AE_LEVEL(1)) u4 (
    .clk(clk), .reset_(reset_), .push(push4), .wr_data(wd4), .pop(pop4), .rd_data(rd4),
    .rd_valid(rv4), .count(count4), .full(full4), .empty(empty4), .almost_full(af4),
    .almost_empty(ae4), .overflow(ovf4), .underflow(unf4), .err_clr(clr4));

  circ_queue_param #(.DATA_W(8), .DEPTH(5), .AF_LEVEL(4), .AE_LEVEL(1)) u5 (
    .clk(clk), .reset_(reset_), .push(push5), .wr_data(wd5), .pop(pop5), .rd_data(rd5),
    .rd_valid(rv5), .count(count5), .full(full5), .empty(empty5), .almost_full(af5),
    .almost_empty(ae5), .overflow(ovf5), .underflow(unf5), .err_clr(clr5));

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  initial forever begin
    @(negedge clk);
    if (rv4) begin
      if (exp4.size() == 0) chk("rd4_unexpected", int'(rd4), -1);
      else chk("rd4_data", int'(rd4), int'(exp4.pop_front()));
    end
    if (rv5) begin
      if (exp5.size() == 0) chk("rd5_unexpected", int'(rd5), -1);
      else chk("rd5_data", int'(rd5), int'(exp5.pop_front()));
    end
  end

  task automatic cyc4(input logic p, input logic [7:0] d, input logic q, input logic c, input int e);
    push4 = p; wd4 = d; pop4 = q; clr4 = c;
    if (e >= 0) exp4.push_back(8'(e));
    @(posedge clk); #1;
    push4 = 1'b0; pop4 = 1'b0; clr4 = 1'b0;
  endtask

  task automatic cyc5(input logic p, input logic [7:0] d, input logic q);
    int sz;
    sz = mq.size();
    push5 = p; wd5 = d; pop5 = q;
    if (q && sz > 0) begin
      exp5.push_back(mq[0]);
      void'(mq.pop_front());
    end
    if (p && (sz < 5 || q)) mq.push_back(d);
    @(posedge clk); #1;
    push5 = 1'b0; pop5 = 1'b0;
    chk("count5", int'(count5), mq.size());
    chk("full5", int'(full5), int'(mq.size() == 5));
  endtask

  initial begin
    #22 reset_ = 1'b1;
    @(posedge clk); #1;
    chk("rst_empty", int'(empty4), 1);
    chk("rst_count", int'(count4), 0);
    chk("rst_rd_valid", int'(rv4), 0);
    chk("rst_ovf", int'(ovf4), 0);
    chk("rst_unf", int'(unf4), 0);
    chk("rst_rd_data", int'(rd4), 0);
    chk("rst_full", int'(full4), 0);
    chk("rst_ae", int'(ae4), 1);
    chk("rst_af", int'(af4), 0);
    cyc4(1, 8'hA1, 0, 0, -1);
    chk("ae_at1", int'(ae4), 1);
    cyc4(1, 8'hA2, 0, 0, -1);
    chk("ae_at2", int'(ae4), 0);
    chk("af_at2", int'(af4), 0);
    cyc4(1, 8'hA3, 0, 0, -1);
    chk("af_at3", int'(af4), 1);
    chk("full_at3", int'(full4), 0);
    cyc4(1, 8'hA4, 0, 0, -1);
    chk("full_at4", int'(full4), 1);
    chk("count_at4", int'(count4), 4);
    cyc4(1, 8'hA5, 0, 0, -1);
    chk("ovf_set", int'(ovf4), 1);
    chk("count_after_ovf", int'(count4), 4);
    cyc4(0, 0, 1, 0, 8'hA1);
    cyc4(0, 0, 1, 0, 8'hA2);
    cyc4(0, 0, 1, 0, 8'hA3);
    cyc4(0, 0, 1, 0, 8'hA4);
    chk("drained_empty", int'(empty4), 1);
    cyc4(0, 0, 0, 1, -1);
    chk("ovf_cleared", int'(ovf4), 0);
    chk("rd_data_hold", int'(rd4), 8'hA4);
    chk("rd_valid_drop", int'(rv4), 0);
    for (int i = 0; i < 4; i++) cyc4(1, 8'(8'h10 + i), 0, 0, -1);
    for (int i = 0; i < 6; i++) begin
      cyc4(1, 8'(8'hB0 + i), 1, 0, (i < 4) ? 8'h10 + i : 8'hB0 + i - 4);
      chk("pp_full_count", int'(count4), 4);
      chk("pp_full_flag", int'(full4), 1);
    end
    cyc4(1, 8'hEE, 0, 1, -1);
    chk("ovf_set_wins", int'(ovf4), 1);
    cyc4(0, 0, 0, 1, -1);
    chk("ovf_clr2", int'(ovf4), 0);
    for (int i = 0; i < 4; i++) cyc4(0, 0, 1, 0, 8'hB2 + i);
    cyc4(1, 8'hC7, 1, 0, -1);
    chk("unf_set", int'(unf4), 1);
    chk("unf_count", int'(count4), 1);
    chk("unf_rd_valid", int'(rv4), 0);
    cyc4(0, 0, 1, 0, 8'hC7);
    chk("after_c7_empty", int'(empty4), 1);
    chk("unf_sticky", int'(unf4), 1);
    for (int i = 0; i < 16; i++)
      cyc5(i < 12, 8'(8'h50 + i), (i >= 3) && (i % 4 != 0));
    while (mq.size() > 0) cyc5(0, 0, 1);
    cyc5(1, 8'h77, 0);
    cyc5(1, 8'h78, 0);
    #2 reset_ = 1'b0;
    #1;
    chk("async_count5", int'(count5), 0);
    chk("async_empty5", int'(empty5), 1);
    chk("async_count4", int'(count4), 0);
    mq.delete();
    #2 reset_ = 1'b1;
    @(posedge clk); #1;
    cyc5(0, 0, 1);
    chk("unf_after_rst", int'(unf5), 1);
    chk("rv_after_rst", int'(rv5), 0);
    @(posedge clk); @(posedge clk); #1;
    chk("exp4_left", exp4.size(), 0);
    chk("exp5_left", exp5.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
